// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op-code encoding, FSM state type and default latencies.
package mdu_ctrl_pkg;

    localparam int MD_OP_W            = 4;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Divides use the longer latency; every other multi-cycle op uses the multiply latency.
    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mdu_ctrl.
// Produces the 64-bit {HI,LO} value an op will eventually write and flags
// whether the op is multi-cycle. When MDU_MADD_EN is defined the
// MADD/MADDU/MSUB/MSUBU accumulate forms are also decoded.
// Divide by zero returns the current {HI,LO} so the write-back is a no-op.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [31:0]        rs_i,
    input  logic [31:0]        rt_i,
    input  logic [63:0]        hilo_i,
    output logic [63:0]        result_o,
    output logic               is_multi_o
);

    logic signed [63:0] rs_sx_s;
    logic signed [63:0] rt_sx_s;
    logic signed [63:0] prod_s_s;
    logic        [63:0] prod_u_s;
    logic signed [31:0] quot_s_s;
    logic signed [31:0] rem_s_s;
    logic        [31:0] quot_u_s;
    logic        [31:0] rem_u_s;
    logic               div_zero_s;
    logic               div_ovf_s;

    // Products and quotients for both signednesses; the one wanted is picked below.
    always_comb begin
        rs_sx_s    = {{32{rs_i[31]}}, rs_i};
        rt_sx_s    = {{32{rt_i[31]}}, rt_i};
        prod_s_s   = rs_sx_s * rt_sx_s;
        prod_u_s   = {32'd0, rs_i} * {32'd0, rt_i};
        div_zero_s = (rt_i == 32'd0);
        div_ovf_s  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
        quot_s_s   = 32'sd0;
        rem_s_s    = 32'sd0;
        quot_u_s   = 32'd0;
        rem_u_s    = 32'd0;
        if (div_zero_s) begin
            quot_s_s = 32'sd0;
            rem_s_s  = 32'sd0;
        end else if (div_ovf_s) begin
            // Most-negative / -1 overflows; the quotient wraps back to the dividend.
            quot_s_s = $signed(32'h8000_0000);
            rem_s_s  = 32'sd0;
        end else begin
            quot_s_s = $signed(rs_i) / $signed(rt_i);
            rem_s_s  = $signed(rs_i) % $signed(rt_i);
        end
        if (div_zero_s) begin
            quot_u_s = 32'd0;
            rem_u_s  = 32'd0;
        end else begin
            quot_u_s = rs_i / rt_i;
            rem_u_s  = rs_i % rt_i;
        end
    end

    // Select the {HI,LO} result and multi-cycle flag for the presented op.
    always_comb begin
        result_o   = hilo_i;
        is_multi_o = 1'b0;
        case (op_i)
            MD_MULT: begin
                result_o   = prod_s_s;
                is_multi_o = 1'b1;
            end
            MD_MULTU: begin
                result_o   = prod_u_s;
                is_multi_o = 1'b1;
            end
            MD_DIV: begin
                result_o   = div_zero_s ? hilo_i : {rem_s_s, quot_s_s};
                is_multi_o = 1'b1;
            end
            MD_DIVU: begin
                result_o   = div_zero_s ? hilo_i : {rem_u_s, quot_u_s};
                is_multi_o = 1'b1;
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                result_o   = hilo_i + prod_s_s;
                is_multi_o = 1'b1;
            end
            MD_MADDU: begin
                result_o   = hilo_i + prod_u_s;
                is_multi_o = 1'b1;
            end
            MD_MSUB: begin
                result_o   = hilo_i - prod_s_s;
                is_multi_o = 1'b1;
            end
            MD_MSUBU: begin
                result_o   = hilo_i - prod_u_s;
                is_multi_o = 1'b1;
            end
`endif
            default: begin
                result_o   = hilo_i;
                is_multi_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO pair.
// An issued MULT/DIV result is computed up front, parked in pend_q and
// written to HI/LO when the latency countdown reaches zero. MTHI/MTLO write
// immediately. stall holds HI/LO users in ID while an op is in flight.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        dataRs,
    input  logic [31:0]        dataRt,
    input  logic               mdUse_ID,
    output logic               busy,
    output logic               stall,
    output logic [31:0]        HI,
    output logic [31:0]        LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        calc_res_s;
    logic               calc_multi_s;

    mdu_calc u_calc (
        .op_i       (op),
        .rs_i       (dataRs),
        .rt_i       (dataRt),
        .hilo_i     ({hi_q, lo_q}),
        .result_o   (calc_res_s),
        .is_multi_o (calc_multi_s)
    );

    // Next-state logic: issue from IDLE, count down in BUSY, commit pend on the last edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    if (calc_multi_s) begin
                        pend_d  = calc_res_s;
                        cnt_d   = md_is_div(op) ? DIV_LOAD : MULT_LOAD;
                        state_d = MD_BUSY;
                    end else if (op == MD_MTHI) begin
                        hi_d = dataRs;
                    end else if (op == MD_MTLO) begin
                        lo_d = dataRs;
                    end else begin
                        state_d = MD_IDLE;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                // Any start seen here is a pipeline bug; it is deliberately ignored.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset discards any in-flight result and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= CNT_ZERO;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == MD_BUSY);
    assign HI    = hi_q;
    assign LO    = lo_q;
    // Also stalls in the issue cycle itself so a dependent op in ID cannot slip past.
    assign stall = mdUse_ID & (busy | (start & calc_multi_s));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan cases followed by
// randomized ops, checked against an arithmetic model of HI/LO and latency.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] dataRs;
    logic [31:0] dataRt;
    logic        mdUse_ID;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests  = 0;
    int failed = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        bit          multi;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dataRs   (dataRs),
        .dataRt   (dataRt),
        .mdUse_ID (mdUse_ID),
        .busy     (busy),
        .stall    (stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op, from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] h,
                                   input logic [31:0] l);
        exp_t e;
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] acc, p;
        e.multi = 1'b0; e.lat = 0; e.hi = h; e.lo = l;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {h, l};
        case (c)
            MD_MULT:  begin e.multi = 1'b1; e.lat = MULT_N; p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_MULTU: begin e.multi = 1'b1; e.lat = MULT_N; p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_DIV: begin
                e.multi = 1'b1; e.lat = DIV_N;
                if (b != 32'd0) begin
                    q = sa / sb; r = sa - q * sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            MD_DIVU: begin
                e.multi = 1'b1; e.lat = DIV_N;
                if (b != 32'd0) begin
                    uq = ua / ub; ur = ua - uq * ub;
                    e.lo = uq[31:0]; e.hi = ur[31:0];
                end
            end
            MD_MTHI: e.hi = a;
            MD_MTLO: e.lo = a;
`ifdef MDU_MADD_EN
            MD_MADD:  begin e.multi = 1'b1; e.lat = MULT_N; p = acc + sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_MADDU: begin e.multi = 1'b1; e.lat = MULT_N; p = acc + ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_MSUB:  begin e.multi = 1'b1; e.lat = MULT_N; p = acc - sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            MD_MSUBU: begin e.multi = 1'b1; e.lat = MULT_N; p = acc - ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Issue one op from idle and follow it through its whole latency.
    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic use_id);
        exp_t e;
        e = model(c, a, b, hi_m, lo_m);
        check("protocol_idle_before_issue", {63'd0, busy}, 64'd0);
        start = 1'b1; op = c; dataRs = a; dataRt = b; mdUse_ID = use_id;
        #1;
        check($sformatf("stall_issue op%0d", c), {63'd0, stall}, {63'd0, use_id & e.multi});
        step();
        start = 1'b0; op = 4'd0;
        for (int i = 0; i < e.lat; i++) begin
            check($sformatf("busy_cyc%0d op%0d", i + 1, c), {63'd0, busy}, 64'd1);
            check($sformatf("stall_busy op%0d", c), {63'd0, stall}, {63'd0, use_id});
            check($sformatf("hilo_hold op%0d", c), {HI, LO}, {hi_m, lo_m});
            step();
        end
        hi_m = e.hi; lo_m = e.lo;
        check($sformatf("busy_done op%0d", c), {63'd0, busy}, 64'd0);
        check($sformatf("stall_done op%0d", c), {63'd0, stall}, 64'd0);
        check($sformatf("hilo_result op%0d a=%h b=%h", c, a, b), {HI, LO}, {hi_m, lo_m});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; dataRs = 32'd0; dataRt = 32'd0; mdUse_ID = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        step(); step();
        // Reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        mdUse_ID = 1'b1; #1;
        check("rst_stall_use_only", {63'd0, stall}, 64'd0);
        start = 1'b1; op = MD_MULT; dataRs = 32'd3; dataRt = 32'd4; #1;
        check("rst_stall_start_multi", {63'd0, stall}, 64'd1);
        step();
        check("rst_wins_busy", {63'd0, busy}, 64'd0);
        op = MD_MTHI; dataRs = 32'hDEAD_BEEF;
        step();
        check("rst_wins_mthi", {HI, LO}, 64'd0);
        reset = 1'b0; start = 1'b0; mdUse_ID = 1'b0; op = 4'd0;
        step();

        // Directed test-plan cases
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check("mult_neg3x5", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg7_by2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
        check("divu_7_by2", {HI, LO}, 64'h0000_0001_0000_0003);
        issue(MD_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b1);
        check("multu_stall_case", {HI, LO}, 64'h0000_0003_0000_0000);
        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_value", {32'd0, HI}, 64'h0000_0000_1234_5678);
        issue(MD_MTHI, 32'h0000_000A, 32'd0, 1'b0);
        issue(MD_MTLO, 32'h0000_000B, 32'd0, 1'b0);
        issue(MD_DIV, 32'd100, 32'd0, 1'b0);
        check("div_by_zero_keeps", {HI, LO}, 64'h0000_000A_0000_000B);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);
        issue(MD_NONE, 32'd9, 32'd9, 1'b1);
        issue(MD_MADDU, 32'd3, 32'd3, 1'b0);
        issue(4'd15, 32'd1, 32'd1, 1'b0);

        // Reset in the third busy cycle of a MULT
        start = 1'b1; op = MD_MULT; dataRs = 32'd7; dataRt = 32'd9; mdUse_ID = 1'b0;
        step();
        start = 1'b0; op = 4'd0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hilo", {HI, LO}, 64'd0);
        for (int i = 0; i < MULT_N + 2; i++) begin
            step();
            check("midrst_no_late_write", {63'd0, busy, HI, LO} , 64'd0);
        end
`ifdef MDU_MADD_EN
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
        check("maddu_carry", {HI, LO}, 64'h0000_0001_0000_0000);
`endif

        // Randomized ops against the model
        for (int n = 0; n < 80; n++) begin
            logic [3:0] rc;
            rc = 4'($urandom_range(0, 15));
            issue(rc, pick_val(), pick_val(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer owning the HI/LO register pair. It accepts one HI/LO operation per issue from the EX stage and models the MULT/DIV latency with a countdown. It drives the pipeline stall for any HI/LO-using instruction in ID while an operation is in flight. It sits beside the EX-stage ALU and feeds MFHI/MFLO read data back into EX.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD family).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  valid HI/LO-writing op in EX this cycle.
- `op`  in  `MD_OP_W` (4)  op code from shared package.
- `dataRs`  in  32  forwarded rs value.
- `dataRt`  in  32  forwarded rt value.
- `mdUse_ID`  in  1  instruction in ID is MULT*/DIV*/MADD*/MSUB*/MTHI/MTLO/MFHI/MFLO.
- `busy`  out  1  multi-cycle op in flight.
- `stall`  out  1  combinational: `mdUse_ID & (busy | (start & op is multi-cycle))`.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.

## Operation
- FSM states: IDLE (`cnt==0`), BUSY (`cnt!=0`); `busy = (cnt!=0)`.
- IDLE, `start`, multi-cycle op: latch 64-bit result into `pend`; set `cnt` to MULT_CYCLES or DIV_CYCLES; go to BUSY.
- IDLE, `start`, MTHI/MTLO: write `dataRs` to HI/LO at that edge. No busy.
- BUSY: `cnt` decrements each edge. On the 1→0 edge, write `pend` into {HI,LO} and return to IDLE.
- `start` while BUSY is ignored. The bench flags it as a protocol error, since `stall` must prevent it.
- MD_NONE, or an unsupported code with `start`: no effect.
- MULT: signed 32×32→64. MULTU: unsigned. HI = result[63:32], LO = result[31:0].
- DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: full busy period runs, HI/LO left unchanged.
- `0x80000000 / -1` signed: LO = 0x80000000, HI = 0.
- MFHI/MFLO are reads only. EX consumes `HI`/`LO` directly and is never issued while `stall` holds it in ID.

## Timing
- Reset: `cnt`=0, `busy`=0, `HI`=0, `LO`=0, `pend`=0. `stall` = 0 unless `mdUse_ID` is high with `start` and a multi-cycle op.
- Reset mid-operation: in-flight result discarded; HI/LO forced to 0 on that edge.
- Issue at edge E:
  - `busy` is high in cycles E+1 … E+N.
  - HI/LO update at edge E+N.
  - `busy` is low and new HI/LO are visible from E+N onward.
- MTHI/MTLO issued at edge E are visible from E onward (1-cycle latency).
- `reset` and `start` on the same edge: reset wins.

## Configuration
- `MDU_MADD_EN` defined: op codes MADD, MADDU, MSUB, MSUBU are supported.
  - {HI,LO} ← {HI,LO} ± product, modulo 2^64, signedness per op.
  - Accumulation uses HI/LO as of the issue edge.
  - Latency is MULT_CYCLES.
- `MDU_MADD_EN` undefined: those four codes are treated as MD_NONE. No adder logic is compiled.

## Structure
- Shared package holds:
  - `MD_OP_W` = 4.
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10.
  - Default cycle counts.
- Sub-module `mdu_calc`: purely combinational.
  - Inputs: `op`, `dataRs`, `dataRt`, `{HI,LO}`.
  - Output: 64-bit result plus `isMulti` flag.
- `mdu_ctrl` holds the counter, the `pend` register, HI/LO and the stall logic.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=5:
  - `busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (−7), rt=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2: LO=3, HI=1.
- MULTU issued while `mdUse_ID`=1 (MFLO in ID):
  - `stall`=1 in the issue cycle and in all 5 busy cycles.
  - `stall` drops the cycle LO becomes valid.
- MTHI 0x12345678 while idle: HI=0x12345678 next cycle; `busy` never asserts.
- DIV rt=0 with HI=0xA, LO=0xB: busy 10 cycles, then HI/LO still 0xA/0xB.
- `reset` asserted at busy cycle 3 of MULT: next cycle `busy`=0, HI=LO=0, and no late write occurs. With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 gives HI=1, LO=0.
